// File: rtl/wishbone_uart_rx_pkg.sv
// Shared definitions for the Wishbone UART receiver: bus widths, register
// offsets, status bit positions and the receive FSM state type.
package wishbone_uart_rx_pkg;

    // Wishbone bus widths, shared with the TX slave on the same interconnect
    localparam int WbAddrWidth = 32;
    localparam int WbDataWidth = 32;
    localparam int WbSelWidth  = 4;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] UartRxDataAddr = 2'd0;
    localparam logic [1:0] UartRxStatAddr = 2'd1;
    localparam logic [1:0] UartRxCtrlAddr = 2'd2;

    // STATUS register bit positions
    localparam int StatNotEmptyBit = 0;
    localparam int StatOverrunBit  = 1;
    localparam int StatFrameErrBit = 2;
    localparam int StatCountLsb    = 8;
    localparam int StatCountMsb    = 15;

    // Receive FSM states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per serial bit (integer division, truncating)
    function automatic int calc_div(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

endpackage

// File: rtl/wishbone_uart_rx_if.sv
// Wishbone slave-side bus bundle for the UART receiver.
// Handshake: the master holds cyc/stb (with addr/we/data) asserted; the slave
// answers with a one-cycle ack, and the transfer completes in that ack cycle.
interface wishbone_uart_rx_if;
    import wishbone_uart_rx_pkg::*;

    logic [WbAddrWidth-1:0] wishbone_addr_i;
    logic [WbDataWidth-1:0] wishbone_data_i;
    logic                   wishbone_we_i;
    logic [WbSelWidth-1:0]  wishbone_sel_i;
    logic                   wishbone_stb_i;
    logic                   wishbone_cyc_i;
    logic [WbDataWidth-1:0] wishbone_data_o;
    logic                   wishbone_ack_o;

    modport master (
        output wishbone_addr_i, wishbone_data_i, wishbone_we_i,
               wishbone_sel_i, wishbone_stb_i, wishbone_cyc_i,
        input  wishbone_data_o, wishbone_ack_o
    );

    modport slave (
        input  wishbone_addr_i, wishbone_data_i, wishbone_we_i,
               wishbone_sel_i, wishbone_stb_i, wishbone_cyc_i,
        output wishbone_data_o, wishbone_ack_o
    );

endinterface

// File: rtl/wishbone_uart_rx_fifo.sv
// uart_rx_fifo: synchronous circular-buffer FIFO for received bytes.
// Pointers carry one extra MSB so full and empty are distinguishable; a push
// while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int FifoDepth = 8,
    parameter int Width     = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           i_push,
    input  logic [Width-1:0]               i_data,
    input  logic                           i_pop,
    output logic [Width-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(FifoDepth):0]     o_count
);
    localparam int Aw   = $clog2(FifoDepth);
    localparam int PtrW = Aw + 1;

    logic [Width-1:0] r_mem [FifoDepth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {Aw{1'b0}}});
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[Aw-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer advance; both may move in the same cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
    end

    // Storage write; when full with a simultaneous pop the slot being
    // overwritten is the head that is leaving this cycle
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[Aw-1:0]] <= i_data;
    end

endmodule

// File: rtl/wishbone_uart_rx.sv
// wishbone_uart_rx: Wishbone slave UART receiver (8N1).
// Synchronizes ser_rx, deframes characters with a bit-period divider, buffers
// them in uart_rx_fifo and exposes RXDATA/STATUS/CTRL registers.
// Optional feature macro: UART_RX_IRQ_EN (adds irq_o and a writable CTRL).
module wishbone_uart_rx
    import wishbone_uart_rx_pkg::*;
#(
    parameter int ClkFreq   = 25000000,
    parameter int BoundRate = 115200,
    parameter int FifoDepth = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    wishbone_uart_rx_if.slave wb,
`ifdef UART_RX_IRQ_EN
    output logic              irq_o,
`endif
    output rx_state_t         o_dbg_state
);
    localparam int Div   = calc_div(ClkFreq, BoundRate);
    localparam int Half  = Div / 2;
    localparam int CntW  = $clog2(Div) + 1;
    localparam int CntAw = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
    localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);

    // Synchronizer and edge detect
    logic r_sync1, r_sync2, r_sync_d;
    logic w_fall;

    // Receive FSM
    rx_state_t        r_state;
    logic [CntW-1:0]  r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_stop_done;
    logic             w_push;
    logic             w_frame_err;
    logic             w_overrun_set;

    // FIFO
    logic             w_pop;
    logic [7:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic [CntAw-1:0] w_count;

    // Bus side
    logic             w_req;
    logic             r_ack;
    logic [1:0]       r_addr;
    logic             r_we;
    logic [2:0]       r_wdata;
    logic             r_rd_pop;
    logic [WbDataWidth-1:0] r_rdata;
    logic [WbDataWidth-1:0] w_rd_data;
    logic             w_stat_wr;
    logic             r_ovr;
    logic             r_ferr;
    logic             w_unused;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= ser_rx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // A falling edge needs a high sample first, so after a low stop bit the
    // receiver naturally waits for the line to return high before re-arming
    assign w_fall = r_sync_d && !r_sync2;

    // Receive FSM: start validation at mid-bit, then one sample per bit period
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt <= '0;
                        if (!r_sync2) begin
                            r_state   <= RX_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == DivLast) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == DivLast) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_dbg_state   = r_state;
    assign w_stop_done   = (r_state == RX_STOP) && (r_cnt == DivLast);
    assign w_push        = w_stop_done && r_sync2;
    assign w_frame_err   = w_stop_done && !r_sync2;
    assign w_overrun_set = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .FifoDepth (FifoDepth),
        .Width     (8)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_req     = wb.wishbone_cyc_i && wb.wishbone_stb_i && !r_ack;
    assign w_pop     = r_ack && r_rd_pop;
    assign w_stat_wr = r_ack && r_we && (r_addr == UartRxStatAddr);

`ifdef UART_RX_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_ctrl_wr;

    assign w_ctrl_wr = r_ack && r_we && (r_addr == UartRxCtrlAddr);

    // CTRL register and registered interrupt output
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= r_wdata[0];
            r_irq <= r_irq_en && (!w_empty || r_ovr || r_ferr);
        end
    end

    assign irq_o = r_irq;
`endif

    // Read data mux, evaluated in the capture cycle
    always_comb begin
        w_rd_data = '0;
        case (wb.wishbone_addr_i[3:2])
            UartRxDataAddr: begin
                if (!w_empty) w_rd_data[7:0] = w_fifo_data;
            end
            UartRxStatAddr: begin
                w_rd_data[StatNotEmptyBit]              = !w_empty;
                w_rd_data[StatOverrunBit]               = r_ovr;
                w_rd_data[StatFrameErrBit]              = r_ferr;
                w_rd_data[StatCountMsb:StatCountLsb]    = 8'(w_count);
            end
`ifdef UART_RX_IRQ_EN
            UartRxCtrlAddr: begin
                w_rd_data[0] = r_irq_en;
            end
`endif
            default: w_rd_data = '0;
        endcase
    end

    // Bus capture: request seen with ack low -> ack next cycle; side effects
    // (pop, W1C, CTRL write) land on the edge that ends the ack cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ack    <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rd_pop <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_addr   <= wb.wishbone_addr_i[3:2];
                r_we     <= wb.wishbone_we_i;
                r_wdata  <= wb.wishbone_data_i[2:0];
                r_rd_pop <= !wb.wishbone_we_i &&
                            (wb.wishbone_addr_i[3:2] == UartRxDataAddr) && !w_empty;
                r_rdata  <= wb.wishbone_we_i ? '0 : w_rd_data;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_stat_wr && r_wdata[StatOverrunBit])  r_ovr  <= 1'b0;
            if (w_stat_wr && r_wdata[StatFrameErrBit]) r_ferr <= 1'b0;
            if (w_overrun_set) r_ovr  <= 1'b1;
            if (w_frame_err)   r_ferr <= 1'b1;
        end
    end

    assign wb.wishbone_ack_o  = r_ack;
    assign wb.wishbone_data_o = r_rdata;

    assign w_unused = ^{wb.wishbone_sel_i, wb.wishbone_addr_i[WbAddrWidth-1:4],
                        wb.wishbone_addr_i[1:0], wb.wishbone_data_i[WbDataWidth-1:3],
                        r_wdata[0]};

endmodule

// File: tb/tb_wishbone_uart_rx.sv
// Directed + randomized bench for wishbone_uart_rx. Frames are bit-banged on
// ser_rx; a byte-queue model of the receive FIFO and sticky flags supplies
// every expected value.
module tb_wishbone_uart_rx;
    import wishbone_uart_rx_pkg::*;

    localparam int ClkFreq   = 25000000;
    localparam int BaudRate  = 115200;
    localparam int Depth     = 8;
    localparam int BitCycles = ClkFreq / BaudRate;
    // Edges from the start-bit negedge to the stop-bit decision edge
    localparam int StopEdge  = 2 + BitCycles / 2 + 9 * BitCycles + 1;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic ser_rx = 1'b1;
    rx_state_t dbg_state;
`ifdef UART_RX_IRQ_EN
    logic irq;
`endif

    wishbone_uart_rx_if wb_if();

    wishbone_uart_rx #(
        .ClkFreq   (ClkFreq),
        .BoundRate (BaudRate),
        .FifoDepth (Depth)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ser_rx      (ser_rx),
        .wb          (wb_if),
`ifdef UART_RX_IRQ_EN
        .irq_o       (irq),
`endif
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       m_ovr;
    logic       m_ferr;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[15:8] = 8'(exp_q.size());
        s[2]    = m_ferr;
        s[1]    = m_ovr;
        s[0]    = (exp_q.size() != 0);
        return s;
    endfunction

    function automatic logic [7:0] model_pop();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q.pop_front();
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (exp_q.size() < Depth) exp_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end on a negedge.
    task automatic bus_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic ack);
        wb_if.wishbone_cyc_i  = 1'b1;
        wb_if.wishbone_stb_i  = 1'b1;
        wb_if.wishbone_we_i   = we;
        wb_if.wishbone_sel_i  = 4'hF;
        wb_if.wishbone_addr_i = {28'h0, a, 2'b00};
        wb_if.wishbone_data_i = wd;
        @(negedge clk);
        ack = wb_if.wishbone_ack_o;
        rd  = wb_if.wishbone_data_o;
        wb_if.wishbone_cyc_i  = 1'b0;
        wb_if.wishbone_stb_i  = 1'b0;
        wb_if.wishbone_we_i   = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ack;
        bus_xfer(1'b0, a, 32'h0, rd, ack);
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wr_check(input string tag, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic        ack;
        bus_xfer(1'b1, a, wd, rd, ack);
        check({tag, "_ack"}, 32'(ack), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = bits[i];
            repeat (BitCycles) @(negedge clk);
        end
        ser_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_frame(b, 1'b1);
        model_frame(b, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        ack;
        logic [7:0]  b;
        logic [7:0]  head;
        logic [31:0] ctrl_exp;

        n_checks = 0;
        n_errors = 0;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
        wb_if.wishbone_cyc_i  = 1'b0;
        wb_if.wishbone_stb_i  = 1'b0;
        wb_if.wishbone_we_i   = 1'b0;
        wb_if.wishbone_sel_i  = 4'h0;
        wb_if.wishbone_addr_i = '0;
        wb_if.wishbone_data_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_if.wishbone_ack_o), 32'd0);
        check("rst_data", wb_if.wishbone_data_o, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(RX_IDLE));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        rd_check("idle_status", UartRxStatAddr, exp_status());
        rd_check("idle_rxdata_empty", UartRxDataAddr, 32'h0);
        rd_check("idle_ctrl", UartRxCtrlAddr, 32'h0);
        wr_check("wr_ctrl", UartRxCtrlAddr, 32'h1);
`ifdef UART_RX_IRQ_EN
        ctrl_exp = 32'h1;
`else
        ctrl_exp = 32'h0;
`endif
        rd_check("ctrl_after_wr", UartRxCtrlAddr, ctrl_exp);
        wr_check("wr_ctrl_clr", UartRxCtrlAddr, 32'h0);
        wr_check("wr_addr3", 2'd3, 32'hFFFF_FFFF);
        rd_check("rd_addr3", 2'd3, 32'h0);

        // Held strobe: ack pulses 1,0,1 then 0 once released
        wb_if.wishbone_cyc_i  = 1'b1;
        wb_if.wishbone_stb_i  = 1'b1;
        wb_if.wishbone_we_i   = 1'b0;
        wb_if.wishbone_addr_i = {28'h0, UartRxStatAddr, 2'b00};
        @(negedge clk);
        check("held_ack1", 32'(wb_if.wishbone_ack_o), 32'd1);
        @(negedge clk);
        check("held_ack2", 32'(wb_if.wishbone_ack_o), 32'd0);
        @(negedge clk);
        check("held_ack3", 32'(wb_if.wishbone_ack_o), 32'd1);
        wb_if.wishbone_cyc_i = 1'b0;
        wb_if.wishbone_stb_i = 1'b0;
        @(negedge clk);
        check("held_ack4", 32'(wb_if.wishbone_ack_o), 32'd0);

        // Frame 0x55
        send_byte(8'h55);
        rd_check("f55_status", UartRxStatAddr, 32'h0000_0101);
        rd_check("f55_data", UartRxDataAddr, 32'(model_pop()));
        rd_check("f55_status_after", UartRxStatAddr, exp_status());

        // Short low glitch on idle line is a false start
        ser_rx = 1'b0;
        repeat (BitCycles / 4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (BitCycles) @(negedge clk);
        check("glitch_state", 32'(dbg_state), 32'(RX_IDLE));
        rd_check("glitch_status", UartRxStatAddr, exp_status());

        // Random bytes
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b);
        end
        rd_check("rand_status", UartRxStatAddr, exp_status());
        for (int i = 0; i < 3; i++) rd_check("rand_data", UartRxDataAddr, 32'(model_pop()));

        // 0xA3 with low stop bit; a W1C of the frame-error bit lands on the
        // same edge that sets it, so the set must win
        fork
            drive_frame(8'hA3, 1'b0);
            begin
                repeat (StopEdge - 2) @(negedge clk);
                bus_xfer(1'b1, UartRxStatAddr, 32'h4, rd, ack);
            end
        join
        check("ferr_w1c_ack", 32'(ack), 32'd1);
        model_frame(8'hA3, 1'b0);
        rd_check("ferr_status", UartRxStatAddr, exp_status());
        wr_check("ferr_clr", UartRxStatAddr, 32'h4);
        m_ferr = 1'b0;
        rd_check("ferr_status_clr", UartRxStatAddr, exp_status());

        // Nine bytes without reads: overrun on the ninth
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        rd_check("ovr_status", UartRxStatAddr, exp_status());
        for (int i = 0; i < 9; i++) rd_check("ovr_data", UartRxDataAddr, 32'(model_pop()));
        rd_check("ovr_status_drained", UartRxStatAddr, exp_status());
        wr_check("ovr_clr", UartRxStatAddr, 32'h2);
        m_ovr = 1'b0;
        rd_check("ovr_status_clr", UartRxStatAddr, exp_status());

        // Full FIFO, pop on the same edge as the stop-bit push
        for (int i = 0; i < Depth; i++) send_byte(8'($urandom_range(0, 255)));
        rd_check("full_status", UartRxStatAddr, exp_status());
        b    = 8'($urandom_range(0, 255));
        head = exp_q[0];
        fork
            drive_frame(b, 1'b1);
            begin
                repeat (StopEdge - 2) @(negedge clk);
                bus_xfer(1'b0, UartRxDataAddr, 32'h0, rd, ack);
            end
        join
        check("simul_ack", 32'(ack), 32'd1);
        check("simul_data", rd, 32'(head));
        void'(model_pop());
        model_frame(b, 1'b1);
        rd_check("simul_status", UartRxStatAddr, exp_status());
        for (int i = 0; i < Depth; i++) rd_check("simul_drain", UartRxDataAddr, 32'(model_pop()));

        // Reset in the middle of a data bit abandons the frame
        ser_rx = 1'b0;
        repeat (BitCycles) @(negedge clk);
        ser_rx = 1'b1;
        repeat (BitCycles + BitCycles / 2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (10 * BitCycles) @(negedge clk);
        check("rst_mid_state", 32'(dbg_state), 32'(RX_IDLE));
        rd_check("rst_mid_status", UartRxStatAddr, exp_status());
        send_byte(8'h7E);
        rd_check("f7e_status", UartRxStatAddr, 32'h0000_0101);
        rd_check("f7e_data", UartRxDataAddr, 32'(model_pop()));
        rd_check("f7e_status_after", UartRxStatAddr, exp_status());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
